// File: rtl/clk_div_bank.sv
// ============================================================================
// clk_div_bank : multi-channel programmable clock-enable (tick) generator
// Option macro: CLK_DIV_BANK_SHADOW_EN (glitch-free divisor change at wrap)
// Revision 1.0
// ============================================================================
`default_nettype none

module clk_div_bank #(
    parameter int NCH      = 4,
    parameter int CW       = 32,
    parameter int DW       = 16,
    parameter int DIV_INIT = 2,
    parameter int CHW      = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NCH-1:0]    en,
    input  logic              cfg_we,
    input  logic [CHW-1:0]    cfg_ch,
    input  logic [DW-1:0]     cfg_div,
    output logic [NCH*CW-1:0] cnt,
    output logic [NCH-1:0]    tick,
    output logic [NCH-1:0]    clk_out
);

    localparam logic [DW-1:0] c_div_init = DW'(DIV_INIT);

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic [CW-1:0] r_cnt;
        logic [DW-1:0] r_ph;
        logic [DW-1:0] r_div;
        logic          r_tick;
        logic          r_clk;
        logic          w_sel;
        logic          w_wrap;
        logic [DW-1:0] w_lim;

        // An out-of-range cfg_ch can never equal a valid channel index.
        assign w_sel  = cfg_we && (cfg_ch == CHW'(i));
        assign w_lim  = (r_div == '0) ? '0 : r_div - DW'(1);
        // >= so a divisor lowered below the current phase wraps at once.
        assign w_wrap = (r_ph >= w_lim);

`ifdef CLK_DIV_BANK_SHADOW_EN
        logic [DW-1:0] r_shadow;
        logic          r_pend;

        always_ff @(posedge clk) begin
            if (!reset) begin
                r_cnt    <= '0;
                r_ph     <= '0;
                r_div    <= c_div_init;
                r_tick   <= 1'b0;
                r_clk    <= 1'b0;
                r_shadow <= c_div_init;
                r_pend   <= 1'b0;
            end else begin
                if (en[i]) begin
                    r_cnt <= r_cnt + CW'(1);
                    if (w_wrap) begin
                        r_ph   <= '0;
                        r_tick <= 1'b1;
                        r_clk  <= ~r_clk;
                        // A write landing on the wrap edge is the newest value.
                        if (w_sel) begin
                            r_div  <= cfg_div;
                            r_pend <= 1'b0;
                        end else if (r_pend) begin
                            r_div  <= r_shadow;
                            r_pend <= 1'b0;
                        end
                    end else begin
                        r_ph   <= r_ph + DW'(1);
                        r_tick <= 1'b0;
                    end
                end else begin
                    r_tick <= 1'b0;
                end
                if (w_sel && !(en[i] && w_wrap)) begin
                    r_shadow <= cfg_div;
                    r_pend   <= 1'b1;
                end
            end
        end
`else
        always_ff @(posedge clk) begin
            if (!reset) begin
                r_cnt  <= '0;
                r_ph   <= '0;
                r_div  <= c_div_init;
                r_tick <= 1'b0;
                r_clk  <= 1'b0;
            end else begin
                if (en[i]) begin
                    r_cnt <= r_cnt + CW'(1);
                end
                if (w_sel) begin
                    r_div  <= cfg_div;
                    r_ph   <= '0;
                    r_tick <= 1'b0;
                end else if (en[i]) begin
                    if (w_wrap) begin
                        r_ph   <= '0;
                        r_tick <= 1'b1;
                        r_clk  <= ~r_clk;
                    end else begin
                        r_ph   <= r_ph + DW'(1);
                        r_tick <= 1'b0;
                    end
                end else begin
                    r_tick <= 1'b0;
                end
            end
        end
`endif

        assign cnt[i*CW +: CW] = r_cnt;
        assign tick[i]         = r_tick;
        assign clk_out[i]      = r_clk;
    end

endmodule

`default_nettype wire

// File: doc/clk_div_bank.md
# clk_div_bank

Multi-channel programmable clock-enable generator. It is the successor to the free-running divider counters used throughout the datapath.

- Provides `NCH` independent channels. Each channel has:
  - a free-running cycle counter;
  - a runtime-programmable divisor;
  - a one-cycle `tick` strobe;
  - a 50% duty `clk_out` toggle.
- All logic runs in the single `clk` domain.
- Downstream blocks (display scan, debounce, slow-step CPU clocking) consume `tick` as a clock enable instead of using derived clocks.

## Interface
Parameters:
- `NCH`, 4, number of channels.
- `CW`, 32, free-running counter width.
- `DW`, 16, divisor and phase-counter width.
- `DIV_INIT`, 2, divisor loaded into every channel at reset.
- `CHW`, `$clog2(NCH)` (minimum 1), channel-select width.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low reset; `reset==0` sampled at a rising edge resets all state.
- `en`  in  NCH  per-channel run enable.
- `cfg_we`  in  1  divisor write strobe.
- `cfg_ch`  in  CHW  channel targeted by the write.
- `cfg_div`  in  DW  new divisor D.
- `cnt`  out  NCH*CW  free-running counters; channel i occupies bits [i*CW +: CW].
- `tick`  out  NCH  registered one-cycle strobe, once per divide period.
- `clk_out`  out  NCH  registered square wave; toggles on every tick, so its period is 2*D cycles.

## Operation
Per-channel state: `cnt` (CW bits), `ph` phase counter (DW bits), `div` (DW bits), `tick`, `clk_out`.

Reset values (`reset==0`), for every channel:
- `cnt=0`, `ph=0`, `div=DIV_INIT`, `tick=0`, `clk_out=0`.
- Reset wins over `en` and `cfg_we` in the same cycle.

Effective divisor: E = max(`div`, 1). D=0 behaves as D=1, which gives a tick every enabled cycle.

When `en[i]==1`, on each rising edge:
- `cnt += 1`, wrapping modulo 2^CW (all-ones → 0).
- If `ph >= E-1`: `ph <= 0`, `tick <= 1`, `clk_out <= ~clk_out`.
- Otherwise: `ph <= ph+1`, `tick <= 0`.

When `en[i]==0`:
- `cnt`, `ph` and `clk_out` hold.
- `tick <= 0`.

`ph >= E-1` (not `==`) is mandatory. It makes a divisor reduced below the current phase wrap on the next enabled cycle.

Divisor write (`cfg_we==1`):
- Applies only to channel `cfg_ch`. If `cfg_ch >= NCH`, the write is ignored. Other channels are unaffected.
- Immediate mode (macro undefined):
  - `div <= cfg_div` and `ph <= 0`. This overrides the increment/wrap for that cycle, and `tick <= 0` that cycle.
  - `cnt` still increments if enabled.
  - `clk_out` holds.
- Writes are legal while `en==0`.

## Timing
- `tick` and `clk_out` are registered; there is no combinational path from any input to any output.
- After reset release, with `en[i]` held high: the first tick is asserted after the E-th rising edge, then repeats every E edges.
- With E=1, `tick` stays high continuously while enabled.
- `cnt` reflects the number of enabled edges since reset, modulo 2^CW.
- Deasserting `en` for k cycles delays the next tick by exactly k cycles; the phase is preserved.
- Asserting `reset` mid-period: all outputs take their reset values at that edge. The phase restarts from 0 when `reset` returns high.

## Configuration
Macro: `CLK_DIV_BANK_SHADOW_EN`.

Defined (glitch-free divisor change):
- A write stores `cfg_div` into a per-channel shadow register and sets a pending flag. It does not touch `div` or `ph`.
- On the edge where the channel wraps (tick generated), `div <= shadow` and pending clears.
- The current period always completes with the old divisor.
- A second write while pending overwrites the shadow (last write wins).

Undefined: immediate mode as described in Operation. No shadow registers exist.

## Test plan
- Reset, `DIV_INIT=2`, `en=4'b1111`: every `tick` pulses on edges 2, 4, 6; `clk_out` toggles 0→1→0; `cnt` reads 6 after 6 edges.
- Write `cfg_ch=1`, `cfg_div=5` while channel 1 runs:
  - Immediate mode: next tick on the 5th edge after the write, then every 5 edges.
  - Shadow build: the current 2-cycle period finishes, then the 5-cycle period starts.
- `cfg_div=0` and `cfg_div=1`: `tick` stays high on every enabled cycle; `clk_out` toggles every cycle.
- Channel 0 with D=4: drop `en[0]` for 3 cycles at `ph=2`. The tick arrives 3 cycles late; `cnt[0]` is frozen during the gap; channels 1-3 are unaffected.
- `CW=4` counter with `en` held: `cnt` goes 15→0 on the 16th edge; `cfg_ch=NCH` (out of range) writes change nothing.
- Assert `reset` low mid-period together with `cfg_we=1`: all outputs are 0 and `div=DIV_INIT` (the write is lost); the first tick comes `DIV_INIT` edges after release.
